// File: rtl/fsm_rx.sv
`default_nettype none
// ============================================================================
// Module   : fsm_rx
// Brief    : UART-style serial receiver with a valid/ready byte output.
// Revision : 1.0 - initial release
// ============================================================================
module fsm_rx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic [2:0] s
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_START   = 3'd1;
    localparam logic [2:0] c_DATA    = 3'd2;
    localparam logic [2:0] c_PARITY  = 3'd3;
    localparam logic [2:0] c_STOP    = 3'd4;
    localparam logic [2:0] c_RECOVER = 3'd5;

    localparam logic [7:0] c_HALF_M1 = 8'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0] c_FULL_M1 = 8'(CLKS_PER_BIT - 1);
    localparam logic       c_PAR_ON  = (PARITY_EN != 0);

    logic       r_sync1;
    logic       r_sync2;
    logic [2:0] r_state;
    logic [7:0] r_cnt;
    logic [2:0] r_bit_idx;
    logic [7:0] r_shift;
    logic       r_par_calc;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_parity_err;
    logic       r_frame_err;
    logic       r_overrun;

    logic w_rxs;
    logic w_tick;
    logic w_done;
    logic w_bad_stop;
    logic w_hs;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs = r_sync2;

    // The start bit is sampled at mid-bit; every later bit one full period on.
    always_comb begin
        w_tick = 1'b0;
        if (r_state == c_START) begin
            w_tick = (r_cnt == c_HALF_M1);
        end else begin
            w_tick = (r_cnt == c_FULL_M1);
        end
    end

    assign w_done     = (r_state == c_STOP) && w_tick && w_rxs;
    assign w_bad_stop = (r_state == c_STOP) && w_tick && !w_rxs;
    assign w_hs       = r_valid && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_cnt      <= 8'd0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
            r_par_calc <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_cnt      <= 8'd0;
                    r_bit_idx  <= 3'd0;
                    r_par_calc <= 1'b0;
                    if (!w_rxs) begin
                        r_state <= c_START;
                    end
                end
                c_START: begin
                    if (w_tick) begin
                        r_cnt   <= 8'd0;
                        r_state <= w_rxs ? c_IDLE : c_DATA;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_DATA: begin
                    if (w_tick) begin
                        r_cnt     <= 8'd0;
                        r_shift   <= {w_rxs, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= c_PAR_ON ? c_PARITY : c_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_PARITY: begin
                    if (w_tick) begin
                        r_cnt      <= 8'd0;
                        r_par_calc <= (^r_shift) ^ w_rxs;
                        r_state    <= c_STOP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_STOP: begin
                    if (w_tick) begin
                        r_cnt   <= 8'd0;
                        r_state <= w_rxs ? c_IDLE : c_RECOVER;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_RECOVER: begin
                    r_cnt <= 8'd0;
                    // Only a return to idle level re-arms start detection.
                    if (w_rxs) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

    // Output holding register: a byte completing while the old one is held
    // without a handshake is dropped and flagged as an overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data       <= 8'd0;
            r_valid      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_err <= w_bad_stop;
            if (w_done && (!r_valid || ready)) begin
                r_data       <= r_shift;
                r_parity_err <= c_PAR_ON & r_par_calc;
                r_valid      <= 1'b1;
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end
            if (w_done && r_valid && !ready) begin
                r_overrun <= 1'b1;
            end else if (w_hs) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign data       = r_data;
    assign valid      = r_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign s          = r_state;

endmodule
`default_nettype wire
